// File: rtl/acc_cpu_core.sv
`default_nettype none
// ============================================================================
//  Module   : acc_cpu_core
//  Purpose  : Multi-cycle accumulator CPU core. Fetches instructions over a
//             simple read/write memory handshake, decodes an opcode plus an
//             optional indirect bit, and runs a small ALU on AC and DR.
//  Ports    : clk        - single clock, all state changes on rising edge
//             clr        - synchronous active-low reset
//             memoryOut  - memory read data (valid with mem_ready on a read)
//             mem_ready  - memory completes the pending read/write this cycle
//             address    - memory address (AR)
//             memoryIn   - memory write data (AC)
//             read/write - memory requests, held until mem_ready
//             halted     - core stopped by HALT
//             cout       - carry / shift-out flag
//  Config   : define ACC_CPU_INDIRECT_EN to honour the indirect (I) bit;
//             otherwise all addressing is direct.
//  Revision : 1.0 - initial release
// ============================================================================
module acc_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] memoryOut,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] memoryIn,
    output logic              read,
    output logic              write,
    output logic              halted,
    output logic              cout
);

    // FSM state encoding
    localparam logic [2:0] c_ST_FETCH0 = 3'd0;
    localparam logic [2:0] c_ST_FETCH1 = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_INDIR  = 3'd3;
    localparam logic [2:0] c_ST_OPER   = 3'd4;
    localparam logic [2:0] c_ST_EXEC   = 3'd5;
    localparam logic [2:0] c_ST_STORE  = 3'd6;
    localparam logic [2:0] c_ST_HALT   = 3'd7;

    // Opcodes
    localparam logic [2:0] c_OP_ADD    = 3'd0;
    localparam logic [2:0] c_OP_ASHL   = 3'd1;
    localparam logic [2:0] c_OP_XNOR   = 3'd2;
    localparam logic [2:0] c_OP_DIV2   = 3'd3;
    localparam logic [2:0] c_OP_LOAD   = 3'd4;
    localparam logic [2:0] c_OP_STORE  = 3'd5;
    localparam logic [2:0] c_OP_COMP2S = 3'd6;
    localparam logic [2:0] c_OP_HALT   = 3'd7;

    localparam logic [ADDR_W-1:0] c_PC_INC = 1;

`ifdef ACC_CPU_INDIRECT_EN
    localparam logic c_IND_EN = 1'b1;
`else
    localparam logic c_IND_EN = 1'b0;
`endif

    logic [2:0]        r_state;
    logic [2:0]        w_nextState;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_ar;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_dr;
    logic [DATA_W-1:0] r_ac;
    logic              r_cout;

    logic [2:0]        w_opcode;
    logic [ADDR_W-1:0] w_irAddr;
    logic              w_goIndir;
    logic [DATA_W-1:0] w_aluRes;
    logic              w_aluCout;

    assign w_opcode  = r_ir[DATA_W-2:DATA_W-4];
    assign w_irAddr  = r_ir[ADDR_W-1:0];
    // With the feature compiled out the I bit is masked, so INDIR is unreachable.
    assign w_goIndir = c_IND_EN & r_ir[DATA_W-1];

    assign address  = r_ar;
    assign memoryIn = r_ac;
    assign cout     = r_cout;

    // ALU: result and carry for the current instruction, committed in EXEC.
    always_comb begin
        w_aluRes  = r_ac;
        w_aluCout = r_cout;
        case (w_opcode)
            c_OP_ADD:    {w_aluCout, w_aluRes} = {1'b0, r_ac} + {1'b0, r_dr};
            c_OP_ASHL: begin
                w_aluRes  = {r_dr[DATA_W-2:0], 1'b0};
                w_aluCout = r_dr[DATA_W-1];
            end
            c_OP_XNOR:   w_aluRes = ~(r_ac ^ r_dr);
            c_OP_DIV2: begin
                // Arithmetic shift: sign bit is replicated.
                w_aluRes  = {r_dr[DATA_W-1], r_dr[DATA_W-1:1]};
                w_aluCout = r_dr[0];
            end
            c_OP_LOAD:   w_aluRes = r_dr;
            c_OP_COMP2S: w_aluRes = '0 - r_dr;
            default: begin
                w_aluRes  = r_ac;
                w_aluCout = r_cout;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= c_ST_FETCH0;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and request outputs
    always_comb begin
        w_nextState = r_state;
        read        = 1'b0;
        write       = 1'b0;
        halted      = 1'b0;
        case (r_state)
            c_ST_FETCH0: w_nextState = c_ST_FETCH1;
            c_ST_FETCH1: begin
                read = 1'b1;
                if (mem_ready) w_nextState = c_ST_DECODE;
            end
            c_ST_DECODE: begin
                if (w_opcode == c_OP_HALT)       w_nextState = c_ST_HALT;
                else if (w_goIndir)              w_nextState = c_ST_INDIR;
                else if (w_opcode == c_OP_STORE) w_nextState = c_ST_STORE;
                else                             w_nextState = c_ST_OPER;
            end
            c_ST_INDIR: begin
                read = 1'b1;
                if (mem_ready) begin
                    w_nextState = (w_opcode == c_OP_STORE) ? c_ST_STORE : c_ST_OPER;
                end
            end
            c_ST_OPER: begin
                read = 1'b1;
                if (mem_ready) w_nextState = c_ST_EXEC;
            end
            c_ST_EXEC:   w_nextState = c_ST_FETCH0;
            c_ST_STORE: begin
                write = 1'b1;
                if (mem_ready) w_nextState = c_ST_FETCH0;
            end
            c_ST_HALT:   halted = 1'b1;
            default:     w_nextState = c_ST_FETCH0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_pc   <= '0;
            r_ar   <= '0;
            r_ir   <= '0;
            r_dr   <= '0;
            r_ac   <= '0;
            r_cout <= 1'b0;
        end else begin
            case (r_state)
                c_ST_FETCH0: r_ar <= r_pc;
                c_ST_FETCH1: begin
                    if (mem_ready) begin
                        r_ir <= memoryOut;
                        r_pc <= r_pc + c_PC_INC;
                    end
                end
                c_ST_DECODE: r_ar <= w_irAddr;
                c_ST_INDIR: begin
                    if (mem_ready) r_ar <= memoryOut[ADDR_W-1:0];
                end
                c_ST_OPER: begin
                    if (mem_ready) r_dr <= memoryOut;
                end
                c_ST_EXEC: begin
                    r_ac   <= w_aluRes;
                    r_cout <= w_aluCout;
                end
                default: begin
                    // STORE and HALT leave the registers untouched.
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_acc_cpu_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_cpu_core
//  Purpose  : Directed bench for acc_cpu_core with a 16-entry memory model
//             and a controllable mem_ready.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acc_cpu_core;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] memoryOut;
    logic       memReady;
    logic [3:0] address;
    logic [7:0] memoryIn;
    logic       read;
    logic       write;
    logic       halted;
    logic       cout;

    logic [7:0] mem [16];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    assign memoryOut = mem[address];

    acc_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .memoryOut (memoryOut),
        .mem_ready (memReady),
        .address   (address),
        .memoryIn  (memoryIn),
        .read      (read),
        .write     (write),
        .halted    (halted),
        .cout      (cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: capture the write request before the edge, commit it at the edge,
    // then sample 1ns after the edge.
    task automatic tick1();
        logic       doWr;
        logic [3:0] a;
        logic [7:0] d;
        doWr = write && memReady;
        a    = address;
        d    = memoryIn;
        @(posedge clk);
        if (doWr) mem[a] = d;
        #1;
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) tick1();
    endtask

    task automatic doReset();
        clr = 1'b0;
        tick1();
        clr = 1'b1;
    endtask

    task automatic clearMem();
        for (int k = 0; k < 16; k++) mem[k] = 8'h00;
    endtask

    task automatic waitHalt(input int bound, output int n);
        n = 0;
        while (!halted && n < bound) begin
            tick1();
            n++;
        end
        check("haltTimeout", {31'd0, halted}, 32'd1);
    endtask

    int n;
    logic [7:0] expAc;
    int expCycles;

    initial begin
        clr      = 1'b0;
        memReady = 1'b1;
        clearMem();
        #2;

        // ---- Basic program: LOAD 4, ADD 4, HALT ----
        mem[0] = 8'h44; mem[1] = 8'h04; mem[2] = 8'h70; mem[4] = 8'h05;
        doReset();
        check("rstAc",     {24'd0, memoryIn}, 32'h00);
        check("rstAddr",   {28'd0, address}, 32'h0);
        check("rstRead",   {31'd0, read}, 32'd0);
        check("rstWrite",  {31'd0, write}, 32'd0);
        check("rstHalted", {31'd0, halted}, 32'd0);
        check("rstCout",   {31'd0, cout}, 32'd0);
        check("rstPc",     {28'd0, dut.r_pc}, 32'h0);
        check("rstState",  {29'd0, dut.r_state}, 32'd0);
        tick(10);
        check("sumAc",     {24'd0, memoryIn}, 32'h0A);
        check("sumCout",   {31'd0, cout}, 32'd0);
        tick(2);
        check("preHalt",   {31'd0, halted}, 32'd0);
        tick(1);
        check("haltAt13",  {31'd0, halted}, 32'd1);
        check("haltPc",    {28'd0, dut.r_pc}, 32'h3);
        check("haltRead",  {31'd0, read}, 32'd0);
        tick(3);
        check("haltStays", {31'd0, halted}, 32'd1);
        check("haltAcKeep",{24'd0, memoryIn}, 32'h0A);
        doReset();
        check("rstFromHalt", {31'd0, halted}, 32'd0);
        check("rstFromHaltAc", {24'd0, memoryIn}, 32'h00);

        // ---- Indirect LOAD ----
        clearMem();
        mem[0] = 8'hC3; mem[1] = 8'h70; mem[3] = 8'h06; mem[6] = 8'h81;
        doReset();
        waitHalt(40, n);
`ifdef ACC_CPU_INDIRECT_EN
        expAc = 8'h81; expCycles = 9;
`else
        expAc = 8'h06; expCycles = 8;
`endif
        check("indAc",     {24'd0, memoryIn}, {24'd0, expAc});
        check("indCycles", n, expCycles);

        // ---- ALU sequence ----
        clearMem();
        mem[0] = 8'h4A; mem[1] = 8'h0B; mem[2] = 8'h3C; mem[3] = 8'h6D;
        mem[4] = 8'h1E; mem[5] = 8'h2F; mem[6] = 8'h70;
        mem[10] = 8'hFF; mem[11] = 8'h01; mem[12] = 8'h81; mem[13] = 8'h01;
        mem[14] = 8'h40; mem[15] = 8'h0F;
        doReset();
        tick(5);
        check("loadFF",     {24'd0, memoryIn}, 32'hFF);
        check("loadCout",   {31'd0, cout}, 32'd0);
        tick(5);
        check("addWrap",    {24'd0, memoryIn}, 32'h00);
        check("addCarry",   {31'd0, cout}, 32'd1);
        tick(5);
        check("div2Ac",     {24'd0, memoryIn}, 32'hC0);
        check("div2Cout",   {31'd0, cout}, 32'd1);
        tick(5);
        check("comp2sAc",   {24'd0, memoryIn}, 32'hFF);
        check("comp2sHold", {31'd0, cout}, 32'd1);
        tick(5);
        check("ashlAc",     {24'd0, memoryIn}, 32'h80);
        check("ashlCout",   {31'd0, cout}, 32'd0);
        tick(5);
        check("xnorAc",     {24'd0, memoryIn}, 32'h70);
        check("xnorHold",   {31'd0, cout}, 32'd0);
        waitHalt(10, n);
        check("aluHaltPc",  {28'd0, dut.r_pc}, 32'h7);

        // ---- STORE with wait states ----
        clearMem();
        mem[0] = 8'h49; mem[1] = 8'h5F; mem[2] = 8'h70; mem[9] = 8'h3C;
        doReset();
        tick(7);
        memReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick1();
            check("stWrite", {31'd0, write}, 32'd1);
            check("stRead",  {31'd0, read}, 32'd0);
            check("stAddr",  {28'd0, address}, 32'hF);
            check("stData",  {24'd0, memoryIn}, 32'h3C);
        end
        tick1();
        check("stWrite4",   {31'd0, write}, 32'd1);
        check("stNoEarly",  {24'd0, mem[15]}, 32'h00);
        memReady = 1'b1;
        tick1();
        check("stDone",     {31'd0, write}, 32'd0);
        check("stMem",      {24'd0, mem[15]}, 32'h3C);
        check("stState",    {29'd0, dut.r_state}, 32'd0);

        // ---- Reset during a held fetch ----
        memReady = 1'b0;
        tick1();
        check("waitRead",   {31'd0, read}, 32'd1);
        check("waitAddr",   {28'd0, address}, 32'h2);
        tick(2);
        check("waitHeld",   {31'd0, read}, 32'd1);
        doReset();
        check("abortRead",  {31'd0, read}, 32'd0);
        check("abortPc",    {28'd0, dut.r_pc}, 32'h0);
        check("abortAc",    {24'd0, memoryIn}, 32'h00);
        check("abortState", {29'd0, dut.r_state}, 32'd0);

        // ---- PC wrap ----
        for (int k = 0; k < 16; k++) mem[k] = 8'h40;
        memReady = 1'b1;
        doReset();
        tick(75);
        check("pcAtF",      {28'd0, dut.r_pc}, 32'hF);
        tick(2);
        check("pcWrap",     {28'd0, dut.r_pc}, 32'h0);
        check("wrapState",  {29'd0, dut.r_state}, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acc_cpu_core.md
ACC_CPU_CORE -- requirements
Module: acc_cpu_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of AC, DR, IR and memory data; DATA_W >= ADDR_W+4.
REQ-002 SHALL have parameter ADDR_W, default 4: width of PC, AR and address.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clr, input, 1: synchronous active-low reset; clr=0 at a rising clk edge resets the core.
REQ-005 SHALL have port memoryOut, input, DATA_W: read data from memory, valid when mem_ready=1 during read.
REQ-006 SHALL have port mem_ready, input, 1: memory completes the pending read or write in this cycle.
REQ-007 SHALL have port address, output, ADDR_W: equals AR.
REQ-008 SHALL have port memoryIn, output, DATA_W: equals AC.
REQ-009 SHALL have port read, output, 1: read request, held until mem_ready=1.
REQ-010 SHALL have port write, output, 1: write request, held until mem_ready=1.
REQ-011 SHALL have port halted, output, 1: core stopped by HALT.
REQ-012 SHALL have port cout, output, 1: carry/shift-out flag.

Function
REQ-013 Instruction format SHALL be: bit DATA_W-1 = I (indirect); bits DATA_W-2..DATA_W-4 = opcode; bits ADDR_W-1..0 = operand address; other bits ignored.
REQ-014 Opcodes SHALL be: 0 ADD (AC<=AC+DR, cout<=carry), 1 ASHL (AC<=DR<<1, cout<=DR msb), 2 XNOR (AC<=~(AC^DR)), 3 DIV2 (AC<=DR>>>1 arithmetic, cout<=DR lsb), 4 LOAD (AC<=DR), 5 STORE (mem[AR]<=AC), 6 COMP2S (AC<=0-DR), 7 HALT.
REQ-015 cout SHALL change only on ADD, ASHL, DIV2; other opcodes hold it.
REQ-016 FSM states SHALL be FETCH0, FETCH1, DECODE, INDIR, OPER, EXEC, STORE, HALT.
REQ-017 FETCH0: AR<=PC; next FETCH1.
REQ-018 FETCH1: read=1; on mem_ready IR<=memoryOut, PC<=PC+1 mod 2^ADDR_W, next DECODE; else stay.
REQ-019 DECODE: AR<=IR address field; next HALT if opcode 7, else INDIR if I=1, else STORE if opcode 5, else OPER.
REQ-020 INDIR: read=1; on mem_ready AR<=memoryOut[ADDR_W-1:0], next STORE or OPER per opcode; else stay.
REQ-021 OPER: read=1; on mem_ready DR<=memoryOut, next EXEC; else stay.
REQ-022 EXEC: update AC/cout per REQ-014 in one cycle; next FETCH0.
REQ-023 STORE: write=1 with address=AR, memoryIn=AC; on mem_ready next FETCH0; else stay.
REQ-024 HALT: halted=1, read=write=0, no register changes; exit only by reset.
REQ-025 read and write SHALL never be 1 in the same cycle; address and memoryIn SHALL be stable while a request is held.
REQ-026 With mem_ready tied 1: direct ALU/LOAD = 5 cycles, direct STORE = 4, indirect +1, HALT entered 3 cycles after FETCH0.
REQ-027 Arithmetic SHALL be modulo 2^DATA_W; PC wraps from 2^ADDR_W-1 to 0 with no flag.
REQ-028 mem_ready outside read/write cycles SHALL be ignored.

Reset
REQ-029 On clr=0: state FETCH0; PC, AR, IR, DR, AC = 0; cout=0, halted=0, read=0, write=0, in the following cycle.
REQ-030 Reset SHALL take priority over every transition, including mid-wait and HALT; a pending request is abandoned without completion.

Configuration
REQ-031 Macro ACC_CPU_INDIRECT_EN defined: I bit honoured per REQ-019/020.
REQ-032 Macro ACC_CPU_INDIRECT_EN undefined: I bit ignored, INDIR never entered, all addressing direct.

Verification
REQ-033 Zero-wait memory, mem[0]=0x44 (LOAD 4), mem[4]=0x05, mem[1]=0x04 (ADD 4), mem[2]=0x70 -> AC=0x0A after 10 cycles, halted=1 at cycle 13, PC=3.
REQ-034 mem[0]=0xC3 (LOAD indirect 3), mem[3]=0x06, mem[6]=0x81, mem[1]=0x70 -> with macro AC=0x81; without macro AC=0x06.
REQ-035 AC=0xFF, ADD of 0x01 -> AC=0x00, cout=1; then DIV2 of 0x81 -> AC=0xC0, cout=1; then COMP2S of 0x01 -> AC=0xFF.
REQ-036 STORE 0x5F with AC=0x3C, mem_ready low 3 cycles in STORE -> write held 4 cycles, address=0xF, memoryIn=0x3C stable throughout.
REQ-037 clr=0 during FETCH1 wait with read=1 -> next cycle read=0, PC=0, AC=0, state FETCH0; PC=0xF fetch -> PC wraps to 0x0.
